// File: rtl/dump_ctrl_pkg.sv
// Shared types and widths for the dump-sustain timer initiator.
package dump_ctrl_pkg;

    localparam int unsigned SUSTAIN_W = 4;
    localparam int unsigned REP_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_WAIT = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/dump_sustain_ctrl_sync.sv
// Two-flop synchronizer plus rising-edge register for clk_10k-domain status inputs.
module sync_rise_det (
    input  logic clk_sys,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/dump_sustain_ctrl.sv
// Initiator side of the dump-sustain timer handshake: load, arm, wait for the
// timer start indication and repeat a programmed number of times.
module dump_sustain_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int unsigned GAP_CYC     = 2500,
    parameter int unsigned TIMEOUT_CYC = 400000,
    parameter int unsigned CNT_W       = 19
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 go,
    input  logic [SUSTAIN_W-1:0] sustain_cfg,
    input  logic [REP_W-1:0]     repeat_num,
    input  logic                 abort,
    input  logic                 timer_start,
    output logic                 load,
    output logic [SUSTAIN_W-1:0] dump_sustain_data,
    output logic                 state_start,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic [REP_W-1:0]     cycle_cnt
);

    state_e               state_q, state_d;
    logic [SUSTAIN_W-1:0] data_q, data_d;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic [REP_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 load_q, load_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 ts_rise;
    logic [REP_W-1:0]     cycle_inc_c;
    logic                 timeout_hit_c;
    logic                 gap_end_c;

    sync_rise_det u_ts_sync (
        .clk_sys (clk_sys),
        .rst     (rst),
        .d_async (timer_start),
        .rise    (ts_rise)
    );

    assign cycle_inc_c   = (cycle_q == {REP_W{1'b1}}) ? cycle_q : cycle_q + REP_W'(1);
    assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign gap_end_c     = (cnt_q == CNT_W'(GAP_CYC - 1));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rep_q   <= '0;
            cycle_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rep_q   <= rep_d;
            cycle_q <= cycle_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and registered-output decode; abort takes priority over everything.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rep_d   = rep_q;
        cycle_d = cycle_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go && !abort) begin
                        data_d  = sustain_cfg;
                        rep_d   = (repeat_num == '0) ? REP_W'(1) : repeat_num;
                        cycle_d = '0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: state_d = ST_ARM;
                ST_ARM: begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A start indication wins over a coincident timeout.
                    if (ts_rise) begin
                        cycle_d = cycle_inc_c;
                        if (cycle_inc_c == rep_q) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_GAP;
                        end
                    end else if (timeout_hit_c) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_GAP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (gap_end_c) begin
                        state_d = ST_ARM;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        load_d  = (state_d == ST_LOAD);
        start_d = (state_d == ST_ARM) || (state_d == ST_WAIT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    assign load              = load_q;
    assign dump_sustain_data = data_q;
    assign state_start       = start_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err_timeout       = err_q;
    assign cycle_cnt         = cycle_q;

endmodule
